// File: rtl/gf2_matinv32.sv
// gf2_matinv32 -- sequential GF(2) inverter for a packed 32x32 bit matrix.
//
// Runs Gauss-Jordan elimination on an augmented register pair [A|B].
// A starts as m and B as the identity. Each column takes one PIVOT cycle
// (find the pivot row and swap it into place) and one ELIM cycle (clear the
// column in every other row). When A reaches the identity, B holds the
// inverse. If a column has no pivot, m is singular and the run stops early.
//
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   start     in   request; sampled only while idle
//   m         in   N*N matrix; row i = m[N*i +: N], bit j of the row = column j
//   busy      out  high from the edge after an accepted start until done
//   done      out  one-cycle completion pulse
//   singular  out  result status; valid from done, held until the next done
//   minv      out  inverse, same packing as m; held until the next done
//   check_err out  self-check mismatch; constant 0 unless GF2_MATINV_CHECK_EN
//
// Optional build macro GF2_MATINV_CHECK_EN adds a shadow copy of m and a
// CHECK cycle that multiplies shadow*B and flags any deviation from identity.
module gf2_matinv32 #(
    parameter int N = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [N*N-1:0]   m,
    output logic             busy,
    output logic             done,
    output logic             singular,
    output logic [N*N-1:0]   minv,
    output logic             check_err
);

    localparam int CW = $clog2(N);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_PIVOT = 3'd1;
    localparam logic [2:0] S_ELIM  = 3'd2;
`ifdef GF2_MATINV_CHECK_EN
    localparam logic [2:0] S_CHECK = 3'd3;
`endif

    logic [2:0]      state_q, state_d;
    logic [CW-1:0]   col_q, col_d;
    logic [N-1:0]    a_q [N];
    logic [N-1:0]    a_d [N];
    logic [N-1:0]    b_q [N];
    logic [N-1:0]    b_d [N];
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            sing_q, sing_d;
    logic [N*N-1:0]  minv_q, minv_d;

    logic            piv_found;
    logic [CW-1:0]   piv_row;

`ifdef GF2_MATINV_CHECK_EN
    logic [N*N-1:0]  shadow_q, shadow_d;
    logic            cerr_q, cerr_d;
    logic            prod_ok;

    // shadow * B must equal the identity; B is final by the time CHECK runs.
    always_comb begin
        logic p;
        p       = 1'b0;
        prod_ok = 1'b1;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                p = 1'b0;
                for (int k = 0; k < N; k++) begin
                    p = p ^ (shadow_q[N*i+k] & b_q[k][j]);
                end
                if (p != (i == j)) prod_ok = 1'b0;
            end
        end
    end
`endif

    // Lowest row at or below the current column with a 1 in that column.
    // Scanning downward-to-upward lets the last hit be the lowest index.
    always_comb begin
        piv_found = 1'b0;
        piv_row   = col_q;
        for (int r = N-1; r >= 0; r--) begin
            if (r >= int'(col_q) && a_q[r][col_q]) begin
                piv_found = 1'b1;
                piv_row   = CW'(r);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        a_d     = a_q;
        b_d     = b_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        sing_d  = sing_q;
        minv_d  = minv_q;
`ifdef GF2_MATINV_CHECK_EN
        shadow_d = shadow_q;
        cerr_d   = cerr_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    for (int i = 0; i < N; i++) begin
                        a_d[i]    = m[N*i +: N];
                        b_d[i]    = '0;
                        b_d[i][i] = 1'b1;
                    end
`ifdef GF2_MATINV_CHECK_EN
                    shadow_d = m;
`endif
                    col_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_PIVOT;
                end
            end
            S_PIVOT: begin
                if (piv_found) begin
                    // Swap is a harmless self-assignment when piv_row == col.
                    a_d[col_q]   = a_q[piv_row];
                    a_d[piv_row] = a_q[col_q];
                    b_d[col_q]   = b_q[piv_row];
                    b_d[piv_row] = b_q[col_q];
                    state_d      = S_ELIM;
                end else begin
                    sing_d  = 1'b1;
                    minv_d  = '0;
`ifdef GF2_MATINV_CHECK_EN
                    cerr_d  = 1'b0;
`endif
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            S_ELIM: begin
                for (int k = 0; k < N; k++) begin
                    if (k != int'(col_q) && a_q[k][col_q]) begin
                        a_d[k] = a_q[k] ^ a_q[col_q];
                        b_d[k] = b_q[k] ^ b_q[col_q];
                    end
                end
                if (col_q == CW'(N-1)) begin
`ifdef GF2_MATINV_CHECK_EN
                    state_d = S_CHECK;
`else
                    // Finish is folded into the last elimination edge so done
                    // appears right after it and the done cycle is already idle.
                    for (int k = 0; k < N; k++) begin
                        minv_d[N*k +: N] = b_d[k];
                    end
                    sing_d  = 1'b0;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
`endif
                end else begin
                    col_d   = col_q + 1'b1;
                    state_d = S_PIVOT;
                end
            end
`ifdef GF2_MATINV_CHECK_EN
            S_CHECK: begin
                cerr_d = !prod_ok;
                for (int k = 0; k < N; k++) begin
                    minv_d[N*k +: N] = b_q[k];
                end
                sing_d  = 1'b0;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            col_q   <= '0;
            for (int i = 0; i < N; i++) begin
                a_q[i] <= '0;
                b_q[i] <= '0;
            end
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sing_q  <= 1'b0;
            minv_q  <= '0;
`ifdef GF2_MATINV_CHECK_EN
            shadow_q <= '0;
            cerr_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            for (int i = 0; i < N; i++) begin
                a_q[i] <= a_d[i];
                b_q[i] <= b_d[i];
            end
            busy_q  <= busy_d;
            done_q  <= done_d;
            sing_q  <= sing_d;
            minv_q  <= minv_d;
`ifdef GF2_MATINV_CHECK_EN
            shadow_q <= shadow_d;
            cerr_q   <= cerr_d;
`endif
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign singular = sing_q;
    assign minv     = minv_q;
`ifdef GF2_MATINV_CHECK_EN
    assign check_err = cerr_q;
`else
    assign check_err = 1'b0;
`endif

endmodule

// File: tb/tb_gf2_matinv32.sv
// Testbench for gf2_matinv32: directed cases plus randomized invertible and
// singular matrices, checked against a matrix-algebra reference model.
module tb_gf2_matinv32;

    localparam int N = 32;
`ifdef GF2_MATINV_CHECK_EN
    localparam int LAT = 2*N + 1;
`else
    localparam int LAT = 2*N;
`endif

    typedef logic [N*N-1:0] mat_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    mat_t        m;
    logic        busy, done, singular, check_err;
    mat_t        minv;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    gf2_matinv32 #(.N(N)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .m(m),
        .busy(busy), .done(done), .singular(singular),
        .minv(minv), .check_err(check_err)
    );

    // ---------------- reference model ----------------
    function automatic mat_t ident();
        mat_t r = '0;
        for (int i = 0; i < N; i++) r[N*i+i] = 1'b1;
        return r;
    endfunction

    // Linear unit: y[i] = parity(row i & a).
    function automatic logic [N-1:0] lin(input mat_t mm, input logic [N-1:0] a);
        logic [N-1:0] y = '0;
        for (int i = 0; i < N; i++) y[i] = ^(mm[N*i +: N] & a);
        return y;
    endfunction

    // P = X*Y: row i of P is the XOR of the rows k of Y selected by X[i][k].
    function automatic mat_t matmul(input mat_t x, input mat_t y);
        mat_t p = '0;
        for (int i = 0; i < N; i++)
            for (int k = 0; k < N; k++)
                if (x[N*i+k]) p[N*i +: N] = p[N*i +: N] ^ y[N*k +: N];
        return p;
    endfunction

    // Bitmap of rows where two matrices differ.
    function automatic logic [N-1:0] rowdiff(input mat_t x, input mat_t y);
        logic [N-1:0] d = '0;
        for (int i = 0; i < N; i++) d[i] = (x[N*i +: N] !== y[N*i +: N]);
        return d;
    endfunction

    // First column that lies in the span of the columns before it
    // (where elimination runs out of pivots); -1 if m is invertible.
    function automatic int first_dep_col(input mat_t mm);
        logic [N-1:0] basis [N];
        logic [N-1:0] v;
        logic         ins;
        for (int b = 0; b < N; b++) basis[b] = '0;
        for (int c = 0; c < N; c++) begin
            for (int i = 0; i < N; i++) v[i] = mm[N*i+c];
            ins = 1'b0;
            for (int b = N-1; b >= 0; b--) begin
                if (!ins && v[b]) begin
                    if (basis[b] != '0) v = v ^ basis[b];
                    else begin basis[b] = v; ins = 1'b1; end
                end
            end
            if (!ins) return c;
        end
        return -1;
    endfunction

    function automatic mat_t rand_mat();
        mat_t r;
        for (int i = 0; i < N; i++) r[N*i +: N] = $urandom;
        return r;
    endfunction

    // Random invertible matrix: identity scrambled by row XORs and swaps.
    function automatic mat_t rand_inv();
        mat_t r = ident();
        logic [N-1:0] t;
        int i, j;
        for (int s = 0; s < 64; s++) begin
            i = $urandom_range(N-1);
            j = $urandom_range(N-1);
            if (i != j) r[N*i +: N] = r[N*i +: N] ^ r[N*j +: N];
        end
        for (int s = 0; s < 8; s++) begin
            i = $urandom_range(N-1);
            j = $urandom_range(N-1);
            t = r[N*i +: N];
            r[N*i +: N] = r[N*j +: N];
            r[N*j +: N] = t;
        end
        return r;
    endfunction

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Launch one operation and return the done latency (edges after the
    // accepting edge, -1 on timeout) and the number of busy cycles.
    task automatic run_op(input mat_t mm, input bit inject, output int lat, output int bc);
        @(negedge clk);
        m     = mm;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = -1;
        bc  = 0;
        for (int n = 1; n <= 200; n++) begin
            if (busy) bc++;
            if (n == 3) m = rand_mat();
            if (inject && n == 10) start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            if (done) begin
                lat = n;
                break;
            end
        end
    endtask

    // Full check of one result against the model.
    task automatic check_result(input string tag, input mat_t mm, input int lat);
        int c;
        logic [N-1:0] a;
        c = first_dep_col(mm);
        chk({tag, "_lat"}, 64'(lat), (c < 0) ? 64'(LAT) : 64'(2*c+1));
        chk({tag, "_sing"}, {63'd0, singular}, {63'd0, (c >= 0)});
        chk({tag, "_cerr"}, {63'd0, check_err}, 64'd0);
        if (c < 0) begin
            chk({tag, "_prod"}, 64'(rowdiff(matmul(mm, minv), ident())), 64'd0);
            a = $urandom;
            chk({tag, "_rtrip"}, 64'(lin(minv, lin(mm, a))), 64'(a));
        end else begin
            chk({tag, "_minv0"}, 64'(rowdiff(minv, '0)), 64'd0);
        end
    endtask

    initial begin
        mat_t mm, prev;
        int   lat, bc, p, q, r;

        rst_n = 1'b0;
        start = 1'b0;
        m     = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_sing", {63'd0, singular}, 64'd0);
        chk("rst_cerr", {63'd0, check_err}, 64'd0);
        chk("rst_minv", 64'(rowdiff(minv, '0)), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // identity
        run_op(ident(), 1'b0, lat, bc);
        check_result("ident", ident(), lat);
        chk("ident_busycnt", 64'(bc), 64'(LAT));
        chk("ident_busy_at_done", {63'd0, busy}, 64'd0);
        chk("ident_minv", 64'(rowdiff(minv, ident())), 64'd0);

        // self-inverse: identity with row0 = 3
        mm = ident();
        mm[N-1:0] = 32'h3;
        run_op(mm, 1'b0, lat, bc);
        check_result("row0_3", mm, lat);
        chk("row0_3_minv", 64'(rowdiff(minv, mm)), 64'd0);

        // anti-diagonal: pivot swap at every column
        mm = '0;
        for (int i = 0; i < N; i++) mm[N*i + (N-1-i)] = 1'b1;
        run_op(mm, 1'b0, lat, bc);
        check_result("antidiag", mm, lat);
        chk("antidiag_minv", 64'(rowdiff(minv, mm)), 64'd0);

        // all zero
        run_op('0, 1'b0, lat, bc);
        check_result("zero", '0, lat);
        chk("zero_lat1", 64'(lat), 64'd1);

        // identity with row5 = row3 -> fails at column 5
        mm = ident();
        mm[N*5 +: N] = mm[N*3 +: N];
        run_op(mm, 1'b0, lat, bc);
        check_result("dup53", mm, lat);
        chk("dup53_lat11", 64'(lat), 64'd11);

        run_op(ident(), 1'b0, lat, bc);
        check_result("ident2", ident(), lat);

        // random singular: one row is the XOR of two others
        for (int t = 0; t < 5; t++) begin
            mm = rand_mat();
            p = t;
            q = t + 7;
            r = t + 19;
            mm[N*p +: N] = mm[N*q +: N] ^ mm[N*r +: N];
            run_op(mm, 1'b0, lat, bc);
            check_result("rsing", mm, lat);
        end

        // random invertible; first run also gets a start pulse while busy
        for (int t = 0; t < 1000; t++) begin
            mm = rand_inv();
            run_op(mm, (t == 0), lat, bc);
            check_result("rinv", mm, lat);
        end

        // reset in the middle of an operation
        prev = minv;
        @(negedge clk);
        m     = rand_inv();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (n == 15) begin
                chk("hold_minv", 64'(rowdiff(minv, prev)), 64'd0);
                chk("hold_busy", {63'd0, busy}, 64'd1);
            end
        end
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", {63'd0, busy}, 64'd0);
        chk("mid_rst_done", {63'd0, done}, 64'd0);
        chk("mid_rst_minv", 64'(rowdiff(minv, '0)), 64'd0);
        chk("mid_rst_sing", {63'd0, singular}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        mm = rand_inv();
        run_op(mm, 1'b0, lat, bc);
        check_result("post_rst", mm, lat);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
